// File: rtl/fpmac_dot_seq.sv
// Dot-product sequencer for one shared 5-stage fp16 fpmac: interleaves LAT partial
// sums through the pipeline, drains them, then folds them serially with weight 1.0.
module fpmac_dot_seq #(
    parameter int          LAT   = 5,
    parameter int          CNT_W = 8,
    parameter logic [15:0] ONE   = 16'h3C00
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [15:0]      in_data,
    input  logic [15:0]      w_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      mac_in,
    output logic [15:0]      mac_weight,
    output logic [15:0]      mac_acc,
    input  logic [15:0]      mac_out,
    input  logic             mac_overflow,
    input  logic             mac_sub,
    output logic             busy,
    output logic [15:0]      result,
    output logic             result_valid,
    output logic             result_sub,
    output logic             ovf_flag
);

    localparam int             LW    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int             CW1   = CNT_W + 1;
    localparam logic [LW-1:0]  LAST  = LW'(LAT - 1);
    localparam logic [LW-1:0]  STEP1 = LW'(1);
    localparam logic [CW1-1:0] LATW  = CW1'(LAT);

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, REDUCE, FINAL} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len_q, term, slot, term_nxt;
    logic [LW-1:0]    lane, cnt, step;
    logic [LAT-1:0]   lane_init;
    logic [15:0]      part [LAT];
    logic             fire, issue;
    logic             slot_warm, slot_last;

    // slot_warm: mac_out now carries a real value for this lane; slot_last: every lane seen
    assign slot_warm = {1'b0, slot} >= LATW;
    assign slot_last = ({1'b0, slot} + CW1'(1)) >= LATW;
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        fire       = 1'b0;
        issue      = 1'b0;
        term_nxt   = term;
        mac_in     = '0;
        mac_weight = '0;
        mac_acc    = '0;
        case (state)
            IDLE: begin
                if (start && (len != '0)) state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready = (term < len_q);
                fire     = in_valid && in_ready;
                if (fire) begin
                    mac_in     = in_data;
                    mac_weight = w_data;
                end
                mac_acc  = lane_init[lane] ? 16'h0000 : mac_out;
                term_nxt = term + CNT_W'(fire);
                if ((term_nxt == len_q) && slot_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (cnt == LAST) state_nxt = REDUCE;
            end
            REDUCE: begin
                // one issue at the end of each LAT-cycle step so the previous sum is back
                issue = (cnt == LAST);
                if (issue) begin
                    mac_in     = part[step];
                    mac_weight = ONE;
                    mac_acc    = (step == STEP1) ? part[0] : mac_out;
                    if (step == LAST) state_nxt = FINAL;
                end
            end
            FINAL: begin
                if (cnt == LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            len_q        <= '0;
            term         <= '0;
            slot         <= '0;
            lane         <= '0;
            cnt          <= '0;
            step         <= '0;
            lane_init    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            result_sub   <= 1'b0;
            ovf_flag     <= 1'b0;
            for (int i = 0; i < LAT; i++) part[i] <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            result       <= '0;
                            result_sub   <= 1'b0;
                            result_valid <= 1'b1;
                        end else begin
                            len_q     <= len;
                            ovf_flag  <= 1'b0;
                            term      <= '0;
                            slot      <= '0;
                            lane      <= '0;
                            lane_init <= '1;
                        end
                    end
                end
                ACCUM: begin
                    term            <= term_nxt;
                    lane_init[lane] <= 1'b0;
                    lane            <= (lane == LAST) ? '0 : lane + LW'(1);
                    cnt             <= '0;
                    if (slot != '1)   slot     <= slot + CNT_W'(1);
                    if (slot_warm)    ovf_flag <= ovf_flag | mac_overflow;
                end
                DRAIN: begin
                    part[cnt] <= mac_out;
                    ovf_flag  <= ovf_flag | mac_overflow;
                    cnt       <= (cnt == LAST) ? '0 : cnt + LW'(1);
                    step      <= STEP1;
                end
                REDUCE: begin
                    cnt <= (cnt == LAST) ? '0 : cnt + LW'(1);
                    if (issue) begin
                        step <= step + LW'(1);
                        if (step != STEP1) ovf_flag <= ovf_flag | mac_overflow;
                    end
                end
                FINAL: begin
                    cnt <= (cnt == LAST) ? '0 : cnt + LW'(1);
                    if (cnt == LAST) begin
                        result       <= mac_out;
                        result_sub   <= mac_sub;
                        result_valid <= 1'b1;
                        ovf_flag     <= ovf_flag | mac_overflow;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmac_dot_seq.sv
// Directed bench for fpmac_dot_seq with a behavioural 5-stage fp16 fpmac on the mac_* side.
module tb_fpmac_dot_seq;

    localparam int LAT   = 5;
    localparam int CNT_W = 8;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic [15:0]      in_data = '0;
    logic [15:0]      w_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      mac_in, mac_weight, mac_acc, mac_out;
    logic             mac_overflow, mac_sub;
    logic             busy;
    logic [15:0]      result;
    logic             result_valid, result_sub, ovf_flag;

    int checks = 0;
    int failures = 0;

    logic [15:0] vin [16];
    logic [15:0] vw  [16];

    logic [15:0] got_res;
    logic        got_sub, got_ovf, got_ovf_first, got_ovf_after, got_extra, got_busy_after, busy_seen;
    int          got_lat, got_fires, got_ready;
    int          poke_at = -1;

    always #5 CLK = ~CLK;

    fpmac_dot_seq #(.LAT(LAT), .CNT_W(CNT_W), .ONE(16'h3C00)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len),
        .in_data(in_data), .w_data(w_data), .in_valid(in_valid), .in_ready(in_ready),
        .mac_in(mac_in), .mac_weight(mac_weight), .mac_acc(mac_acc),
        .mac_out(mac_out), .mac_overflow(mac_overflow), .mac_sub(mac_sub),
        .busy(busy), .result(result), .result_valid(result_valid),
        .result_sub(result_sub), .ovf_flag(ovf_flag)
    );

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        m = real'(h[9:0]);
        if (e == 31)     m = 1.0e30;
        else if (e == 0) m = m * (2.0 ** (-24));
        else             m = (1.0 + m / 1024.0) * (2.0 ** (e - 15));
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        real        m;
        int         e;
        logic       s;
        logic [9:0] f;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while ((m < 1.0) && (e > 1)) begin m = m * 2.0; e--; end
        f = 10'($rtoi((m - 1.0) * 1024.0));
        return {s, 5'(e), f};
    endfunction

    // Reference fpmac: in*weight+acc, overflow saturates to 0xFC00, LAT-deep pipeline
    logic [15:0] pipe_v [LAT];
    logic        pipe_o [LAT];

    always @(posedge CLK) begin : fpmac_model
        real r;
        if (!RST) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_v[i] <= 16'h0000;
                pipe_o[i] <= 1'b0;
            end
        end else begin
            r = h2r(mac_in) * h2r(mac_weight) + h2r(mac_acc);
            pipe_o[0] <= (r > 65504.0) || (r < -65504.0);
            pipe_v[0] <= ((r > 65504.0) || (r < -65504.0)) ? 16'hFC00 : r2h(r);
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_o[i] <= pipe_o[i-1];
            end
        end
    end

    assign mac_out      = pipe_v[LAT-1];
    assign mac_overflow = pipe_o[LAT-1];
    assign mac_sub      = 1'b0;

    task automatic load_all(input logic [15:0] a, input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            vin[i] = a;
            vw[i]  = w;
        end
    endtask

    // Runs one operation; got_lat counts clock edges from the start-sampling edge to result_valid
    task automatic run_op(input int n, input bit stall);
        int idx, cyc;
        bit fire, done;
        idx = 0; cyc = 0; done = 0;
        got_fires = 0; got_ready = 0; got_lat = -1; got_res = 16'h0000;
        @(negedge CLK);
        start = 1'b1;
        len   = CNT_W'(n);
        @(posedge CLK); #1;
        start = 1'b0;
        got_ovf_first = ovf_flag;
        busy_seen     = busy;
        if (result_valid) begin
            done = 1; got_lat = 0; got_res = result; got_sub = result_sub; got_ovf = ovf_flag;
        end
        while (!done && (cyc < 500)) begin
            start    = (cyc == poke_at);
            len      = (cyc == poke_at) ? CNT_W'(2) : CNT_W'(n);
            in_valid = (idx < n) && (!stall || (cyc % 3 == 0));
            in_data  = vin[idx % 16];
            w_data   = vw[idx % 16];
            @(negedge CLK);
            fire = in_valid && in_ready;
            if (in_ready) got_ready++;
            if (fire)     got_fires++;
            @(posedge CLK); #1;
            cyc++;
            if (fire) idx++;
            if (busy) busy_seen = 1'b1;
            if (result_valid) begin
                done = 1; got_lat = cyc; got_res = result; got_sub = result_sub; got_ovf = ovf_flag;
            end
        end
        start = 1'b0; in_valid = 1'b0; len = CNT_W'(n);
        checks++;
        if (!done) begin failures++; $display("[TB] FAIL op_timeout len=%0d got=no result_valid exp=result_valid", n); end
        @(posedge CLK); #1;
        got_extra      = result_valid;
        got_busy_after = busy;
        got_ovf_after  = ovf_flag;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (busy !== 1'b0)         begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", result_valid); end
        checks++; if (result !== 16'h0000)   begin failures++; $display("[TB] FAIL reset_result got=%h exp=0000", result); end
        checks++; if (ovf_flag !== 1'b0)     begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", ovf_flag); end
        checks++; if (in_ready !== 1'b0)     begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", in_ready); end
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_basic();
        load_all(16'h3C00, 16'h3C00);
        run_op(8, 1'b0);
        checks++; if (got_res !== 16'h4800)  begin failures++; $display("[TB] FAIL basic_result got=%h exp=4800", got_res); end
        checks++; if (got_lat != 38)         begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=38", got_lat); end
        checks++; if (got_fires != 8)        begin failures++; $display("[TB] FAIL basic_fires got=%0d exp=8", got_fires); end
        checks++; if (got_ready != 8)        begin failures++; $display("[TB] FAIL basic_ready_cycles got=%0d exp=8", got_ready); end
        checks++; if (got_ovf !== 1'b0)      begin failures++; $display("[TB] FAIL basic_ovf got=%b exp=0", got_ovf); end
        checks++; if (got_sub !== 1'b0)      begin failures++; $display("[TB] FAIL basic_sub got=%b exp=0", got_sub); end
        checks++; if (got_extra !== 1'b0)    begin failures++; $display("[TB] FAIL basic_pulse_width got=%b exp=0", got_extra); end
        checks++; if (got_busy_after !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_after got=%b exp=0", got_busy_after); end
    endtask

    task automatic test_short();
        load_all(16'h3C00, 16'h3C00);
        vin[0] = 16'h3C00; vin[1] = 16'h4000; vin[2] = 16'h4200;
        run_op(3, 1'b0);
        checks++; if (got_res !== 16'h4600) begin failures++; $display("[TB] FAIL short_result got=%h exp=4600", got_res); end
        checks++; if (got_lat != 35)        begin failures++; $display("[TB] FAIL short_latency got=%0d exp=35", got_lat); end
        checks++; if (got_fires != 3)       begin failures++; $display("[TB] FAIL short_fires got=%0d exp=3", got_fires); end
        checks++; if (got_ready != 3)       begin failures++; $display("[TB] FAIL short_ready_cycles got=%0d exp=3", got_ready); end
    endtask

    task automatic test_stall();
        load_all(16'h3C00, 16'h3C00);
        run_op(8, 1'b1);
        checks++; if (got_res !== 16'h4800) begin failures++; $display("[TB] FAIL stall_result got=%h exp=4800", got_res); end
        checks++; if (got_fires != 8)       begin failures++; $display("[TB] FAIL stall_fires got=%0d exp=8", got_fires); end
        checks++; if (got_lat != 52)        begin failures++; $display("[TB] FAIL stall_latency got=%0d exp=52", got_lat); end
    endtask

    task automatic test_overflow();
        load_all(16'h7BFF, 16'h7BFF);
        run_op(2, 1'b0);
        checks++; if (got_res !== 16'hFC00)   begin failures++; $display("[TB] FAIL ovf_result got=%h exp=fc00", got_res); end
        checks++; if (got_ovf !== 1'b1)       begin failures++; $display("[TB] FAIL ovf_flag got=%b exp=1", got_ovf); end
        checks++; if (got_ovf_after !== 1'b1) begin failures++; $display("[TB] FAIL ovf_held got=%b exp=1", got_ovf_after); end
        load_all(16'h3C00, 16'h3C00);
        run_op(8, 1'b0);
        checks++; if (got_ovf_first !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear_on_start got=%b exp=0", got_ovf_first); end
        checks++; if (got_res !== 16'h4800)   begin failures++; $display("[TB] FAIL ovf_next_result got=%h exp=4800", got_res); end
    endtask

    task automatic test_zero();
        run_op(0, 1'b0);
        checks++; if (got_lat != 0)             begin failures++; $display("[TB] FAIL zero_latency got=%0d exp=0", got_lat); end
        checks++; if (got_res !== 16'h0000)     begin failures++; $display("[TB] FAIL zero_result got=%h exp=0000", got_res); end
        checks++; if (busy_seen !== 1'b0)       begin failures++; $display("[TB] FAIL zero_busy got=%b exp=0", busy_seen); end
        checks++; if (got_extra !== 1'b0)       begin failures++; $display("[TB] FAIL zero_pulse_width got=%b exp=0", got_extra); end
        checks++; if (got_busy_after !== 1'b0)  begin failures++; $display("[TB] FAIL zero_busy_after got=%b exp=0", got_busy_after); end
    endtask

    task automatic test_busy_start();
        load_all(16'h3C00, 16'h3C00);
        poke_at = 10;
        run_op(8, 1'b0);
        poke_at = -1;
        checks++; if (got_res !== 16'h4800) begin failures++; $display("[TB] FAIL busy_start_result got=%h exp=4800", got_res); end
        checks++; if (got_lat != 38)        begin failures++; $display("[TB] FAIL busy_start_latency got=%0d exp=38", got_lat); end
    endtask

    task automatic test_reset_abort();
        bit seen;
        seen = 1'b0;
        load_all(16'h3C00, 16'h3C00);
        @(negedge CLK);
        start = 1'b1; len = CNT_W'(8);
        in_valid = 1'b1; in_data = 16'h3C00; w_data = 16'h3C00;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)     begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL abort_ready got=%b exp=0", in_ready); end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(posedge CLK); #1;
            if (result_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL abort_no_result got=%b exp=0", seen); end
        run_op(8, 1'b0);
        checks++; if (got_res !== 16'h4800) begin failures++; $display("[TB] FAIL abort_rerun_result got=%h exp=4800", got_res); end
        checks++; if (got_lat != 38)        begin failures++; $display("[TB] FAIL abort_rerun_latency got=%0d exp=38", got_lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_stall();
        test_overflow();
        test_zero();
        test_busy_start();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpmac_dot_seq.md
Name: fpmac_dot_seq

Overview:
Sequencer that drives one shared fpmac instance (fp16 multiply-accumulate, 5-cycle pipeline, acc input internally aligned) to compute a dot product of LEN input/weight pairs arriving on a valid/ready stream.
- Hides the 5-cycle feedback latency by keeping LAT independent partial sums (lanes) circulating in the fpmac pipeline, issuing one slot per cycle.
- Drains and collects the partials, then reduces them serially through the same fpmac using weight 1.0.
- Sits between the weight/activation fetch logic and the fpmac.

Parameters:
LAT, 5, fpmac latency in cycles: slot values on mac_* during cycle t produce mac_out during cycle t+LAT.
CNT_W, 8, width of len and the internal term counter.
ONE, 16'h3C00, fp16 constant 1.0 used as the reduction weight.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
start  input  1  begin an operation; sampled only in IDLE
len  input  CNT_W  number of terms, latched on start
in_data  input  16  fp16 activation
w_data  input  16  fp16 weight
in_valid  input  1  stream valid
in_ready  output  1  stream ready (combinational)
mac_in  output  16  to fpmac in (combinational)
mac_weight  output  16  to fpmac weight (combinational)
mac_acc  output  16  to fpmac acc (combinational)
mac_out  input  16  from fpmac out
mac_overflow  input  1  from fpmac overflow
mac_sub  input  1  from fpmac sub
busy  output  1  high in any state except IDLE
result  output  16  final dot product, held until the next result
result_valid  output  1  one-cycle pulse
result_sub  output  1  mac_sub captured with result
ovf_flag  output  1  sticky overflow; cleared on an accepted start, held after result

Behaviour:
- States: IDLE, ACCUM, DRAIN, REDUCE, FINAL.
- Reset: state IDLE; all counters 0; part[] 0; result, result_valid, result_sub, ovf_flag, busy 0. Reset mid-operation aborts immediately with no result_valid.
- Bubble slot: in=0, weight=0. Its acc value is set per state, as below.
- IDLE:
  - mac_* driven 0; in_ready 0.
  - start with len==0: next cycle result=0, result_sub=0, result_valid=1; stay IDLE.
  - start with len>0: latch len, clear ovf_flag, term=0, slot=0, lane_init all 1; go to ACCUM.
  - start while busy is ignored.
- ACCUM:
  - lane = slot mod LAT.
  - in_ready = (term<len).
  - Fire (in_valid && in_ready): mac_in=in_data, mac_weight=w_data; term increments.
  - No fire: bubble slot.
  - mac_acc = lane_init[lane] ? 0 : mac_out. lane_init[lane] clears after the slot.
  - slot increments every cycle; stalls therefore never corrupt partials.
  - Exit to DRAIN at the end of a cycle where term==len after that cycle's fire and slot+1>=LAT. This guarantees every lane was initialised.
- DRAIN (LAT cycles, j=0..LAT-1):
  - Bubble slot with mac_acc=0.
  - Capture part[j]=mac_out. These are the final values of all LAT lanes, in any order.
  - Then go to REDUCE with k=1.
- REDUCE:
  - Step k=1..LAT-1 issues in=part[k], weight=ONE, acc = (k==1 ? part[0] : mac_out).
  - Exactly one issue every LAT cycles; other cycles are bubble slots with acc=0.
  - After issuing k=LAT-1, go to FINAL.
- FINAL:
  - Bubble slots with acc=0.
  - LAT cycles after the last issue: result=mac_out, result_sub=mac_sub, result_valid=1; go to IDLE.
- ovf_flag: ORs mac_overflow during ACCUM cycles with slot>=LAT, all of DRAIN, and cycles in REDUCE/FINAL where a reduction result emerges.
- Latency: with no stalls and len>=LAT, result_valid occurs len + LAT + (LAT-1)*LAT + LAT cycles after start. For LAT=5: len+30.
- Overflowed partials are 0xFC00 and propagate through the adds; no special handling.
- Counters saturate per CNT_W. Maximum len is 2^CNT_W-1.

Test Plan:
- len=8, all pairs 0x3C00×0x3C00, in_valid always 1 -> in_ready high for exactly 8 cycles; result=0x4800 (8.0) at start+38; ovf_flag=0; result_valid one cycle.
- len=3, in=[0x3C00,0x4000,0x4200], w all 0x3C00 -> lanes 3,4 stay 0 and ACCUM lasts 5 cycles; result=0x4600 (6.0).
- Same as case 1 with in_valid toggling 1,0,0,1,… -> identical result 0x4800; exactly 8 fires; finish delayed by the number of stall cycles.
- len=2, pairs 0x7BFF×0x7BFF -> ovf_flag=1, result=0xFC00; next start clears ovf_flag.
- len=0 start -> result=0x0000 with result_valid one cycle later; busy never rises. A start pulse during busy is ignored.
- RST low for 1 cycle mid-ACCUM of a len=8 op -> busy=0, no result_valid; a fresh len=8 op afterwards gives 0x4800.
